instr_fetch_unit: RTL and testbench

Instruction fetch stage for the RV32 core: owns the program counter, issues word fetches to instruction memory, buffers returned words, and presents `inst` to the control unit. It consumes the control unit's `PCsrc` redirect and the branch target from the datapath, flushing wrong-path instructions. It sits between instruction memory and the decode/control stage.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 66 ++++++
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ==== fetch_pkg : shared constants and types for the instruction fetch stage ====
// Rev 1.0
package fetch_pkg;

    localparam int          FETCH_XLEN       = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ==== fetch_buffer : small power-of-two FIFO of {pc, inst}; flush beats push/pop ====
// Rev 1.0
module fetch_buffer #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage is reset so the head pc/inst read a defined value before the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ==== instr_fetch_unit : RV32 fetch stage - PC, single-outstanding imem fetch, instruction buffer ====
// Rev 1.0
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            PCsrc,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_valid
);

    localparam int              CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam int              ENTRY_W = XLEN + 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    fetch_pc_nxt;
    logic [CNT_W-1:0]   buf_count;
    logic [CNT_W-1:0]   wait_fill;
    logic               buf_full;
    logic               buf_empty;
    logic               push;
    logic               pop;
    logic               accept;
    logic               in_flight;
    logic [ENTRY_W-1:0] head;
    logic               target_unused;

    assign target_unused = ^branch_target[1:0];

    assign pop       = !buf_empty && !stall;
    // Occupancy once the returning word lands; another fetch is allowed only if a slot stays free.
    assign wait_fill = buf_count + CNT_W'(1) - CNT_W'(pop);
    assign imem_req  = ((state == ST_REQ) && !buf_full) ||
                       ((state == ST_WAIT) && imem_rvalid && (wait_fill < CNT_W'(BUF_DEPTH)));
    assign accept    = imem_req && imem_ready;
    assign in_flight = accept || (((state == ST_WAIT) || (state == ST_DROP)) && !imem_rvalid);
    assign push      = (state == ST_WAIT) && imem_rvalid;
    assign imem_addr = fetch_pc;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        if (accept) begin
            fetch_pc_nxt = fetch_pc + PC_STEP;
        end
        case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ:  if (accept) state_nxt = ST_WAIT;
            ST_WAIT: if (imem_rvalid) state_nxt = accept ? ST_WAIT : ST_REQ;
            ST_DROP: if (imem_rvalid) state_nxt = ST_REQ;
            default: state_nxt = ST_IDLE;
        endcase
        // Anything still in flight after a redirect is wrong-path and must be swallowed.
        if (PCsrc) begin
            fetch_pc_nxt = {branch_target[XLEN-1:2], 2'b00};
            state_nxt    = in_flight ? ST_DROP : ST_REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    // In WAIT the outstanding word's address is one step behind fetch_pc.
    fetch_buffer #(
        .DEPTH     (BUF_DEPTH),
        .WIDTH     (ENTRY_W),
        .RESET_VAL ({RESET_PC, NOP_INST})
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({fetch_pc - PC_STEP, imem_rdata}),
        .pop       (pop),
        .flush     (PCsrc),
        .head      (head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign inst_valid = !buf_empty;
    assign inst       = buf_empty ? NOP_INST : head[31:0];
    assign inst_pc    = head[ENTRY_W-1:32];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ==== tb_instr_fetch_unit : randomized bench with an in-order stream model of the fetch stage ====
// Rev 1.0
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        PCsrc;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RPC), .BUF_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .PCsrc         (PCsrc),
        .branch_target (branch_target),
        .stall         (stall),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pops = 0;
    int          fixed_lat = 1;
    bit          rand_mode = 1'b0;
    logic [31:0] exp_fetch = RPC;
    logic [31:0] exp_pc = RPC;
    bit          redir_prev = 1'b0;
    bit          hold_prev = 1'b0;
    logic [31:0] hold_addr = '0;
    mreq_t       m;
    int          lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: in-order responses, due a chosen number of cycles after accept.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0 && q[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(q[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
        end
    end

    // Reference: fetch addresses and delivered instructions are each a sequential stream
    // that restarts at the aligned target on every redirect and at RESET_PC on reset.
    always @(negedge clk) begin
        if (rst) begin
            exp_fetch  = RPC;
            exp_pc     = RPC;
            redir_prev = 1'b0;
            hold_prev  = 1'b0;
            if (imem_rvalid && q.size() > 0) void'(q.pop_front());
        end else begin
            if (!inst_valid) chk("nop_when_invalid", inst, NOP);
            if (redir_prev) chk("valid_after_redirect", 32'(inst_valid), 32'd0);
            if (hold_prev && imem_req) chk("addr_stable", imem_addr, hold_addr);
            if (imem_rvalid && q.size() > 0) void'(q.pop_front());
            if (imem_req && imem_ready) begin
                chk("single_outstanding", 32'(q.size()), 32'd0);
                chk("fetch_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                lat = rand_mode ? int'($urandom_range(1, 3)) : fixed_lat;
                m.addr = imem_addr;
                m.due  = cyc + lat;
                q.push_back(m);
            end
            if (inst_valid && !stall && !PCsrc) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst_word", inst, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (PCsrc) begin
                exp_fetch = {branch_target[31:2], 2'b00};
                exp_pc    = {branch_target[31:2], 2'b00};
            end
            redir_prev = PCsrc;
            hold_prev  = imem_req && !imem_ready && !PCsrc;
            hold_addr  = imem_addr;
        end
        cyc++;
    end

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pop(input logic [31:0] want, input string name);
        bit got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            peek();
            if (inst_valid && !stall) begin
                got = 1'b1;
                chk(name, inst_pc, want);
            end
        end
        if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_outstanding(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            if (q.size() > 0) got = 1'b1;
        end
        if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int pops_before;
        rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; PCsrc = 1'b0; branch_target = '0;

        peek();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_inst", inst, NOP);
        chk("rst_inst_pc", inst_pc, RPC);
        chk("rst_valid", 32'(inst_valid), 32'd0);

        step(); rst = 1'b0; imem_ready = 1'b1; fixed_lat = 1;
        peek(); chk("idle_no_req", 32'(imem_req), 32'd0);
        peek(); chk("first_req", 32'(imem_req), 32'd1); chk("first_addr", imem_addr, 32'h0);
        peek(); chk("second_addr", imem_addr, 32'h4); chk("c2_invalid", 32'(inst_valid), 32'd0);
        peek(); chk("third_addr", imem_addr, 32'h8); chk("c3_valid", 32'(inst_valid), 32'd1);
        chk("c3_pc", inst_pc, 32'h0); chk("c3_inst", inst, 32'hC3A5_0F13);

        step(); stall = 1'b1;
        repeat (5) peek();
        chk("stall_req_off", 32'(imem_req), 32'd0);
        chk("stall_head_pc", inst_pc, 32'h4);
        chk("stall_head_inst", inst, 32'hC3A1_0F13);
        step(); stall = 1'b0;
        repeat (10) step();

        imem_ready = 1'b0;
        repeat (3) peek();
        chk("ready_low_req", 32'(imem_req), 32'd1);
        step(); PCsrc = 1'b1; branch_target = 32'h0000_0200;
        step(); PCsrc = 1'b0;
        peek(); chk("redir_req", 32'(imem_req), 32'd1); chk("redir_addr", imem_addr, 32'h200);
        step(); imem_ready = 1'b1;
        repeat (6) step();

        fixed_lat = 3;
        wait_outstanding("redir_wait");
        PCsrc = 1'b1; branch_target = 32'h0000_0100;
        step(); PCsrc = 1'b0;
        wait_pop(32'h100, "redir_first_pc");
        repeat (6) step();

        wait_outstanding("reset_wait");
        rst = 1'b1; imem_ready = 1'b0;
        peek();
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_valid", 32'(inst_valid), 32'd0);
        step(); rst = 1'b0;
        repeat (3) step();
        imem_ready = 1'b1;
        wait_pop(RPC, "post_reset_pc");

        fixed_lat = 1;
        step(); PCsrc = 1'b1; branch_target = 32'hFFFF_FFFC;
        step(); PCsrc = 1'b0;
        wait_pop(32'hFFFF_FFFC, "wrap_pc0");
        wait_pop(32'h0000_0000, "wrap_pc1");

        rand_mode = 1'b1;
        pops_before = pops;
        for (int i = 0; i < 4000; i++) begin
            step();
            imem_ready = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            PCsrc      = ($urandom_range(0, 29) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
        end
        step(); imem_ready = 1'b1; stall = 1'b0; PCsrc = 1'b0;
        repeat (20) step();
        chk("random_progress", 32'(pops - pops_before > 300), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
